// File: rtl/phys_free_list_if.sv
// rtl/phys_free_list_if.sv - allocate/return handshake bundle of the physical register free list
//
// Signals:
//   alloc_req     rename consumes the head tag this cycle
//   alloc_valid   list non-empty, alloc_phys is meaningful
//   alloc_phys    head tag, show-ahead
//   free_en       commit returns a tag
//   free_phys     tag being returned
//   free_count    number of tags currently free
//   err_dup       sticky: a returned tag was already free
//   err_overflow  sticky: a return was attempted with the list full
// Modports: master = rename/commit side, slave = free list.
interface phys_free_list_if #(
    parameter int PHYS_W = 6
);
    logic              alloc_req;
    logic              alloc_valid;
    logic [PHYS_W-1:0] alloc_phys;
    logic              free_en;
    logic [PHYS_W-1:0] free_phys;
    logic [PHYS_W:0]   free_count;
    logic              err_dup;
    logic              err_overflow;

    modport master (
        output alloc_req, free_en, free_phys,
        input  alloc_valid, alloc_phys, free_count, err_dup, err_overflow
    );

    modport slave (
        input  alloc_req, free_en, free_phys,
        output alloc_valid, alloc_phys, free_count, err_dup, err_overflow
    );
endinterface

// File: rtl/phys_free_list.sv
// rtl/phys_free_list.sv - circular FIFO of free physical register tags with membership bitmap
//
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   fl    phys_free_list_if.slave: allocate port (alloc_req/alloc_valid/alloc_phys),
//         return port (free_en/free_phys), free_count and sticky error flags
//
// After reset tags 0..NUM_ARCH-1 are held by the identity architectural mapping and
// tags NUM_ARCH..NUM_PHYS-1 are queued in ascending order. Tag 0 (x0) never re-enters
// the list, so at most NUM_PHYS-1 tags can ever be free.
module phys_free_list #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int PHYS_W   = 6
) (
    input  logic           clk,
    input  logic           rst,
    phys_free_list_if.slave fl
);
    localparam logic [PHYS_W:0]     COUNT_INIT = (PHYS_W+1)'(NUM_PHYS - NUM_ARCH);
    localparam logic [PHYS_W:0]     COUNT_FULL = (PHYS_W+1)'(NUM_PHYS - 1);
    localparam logic [PHYS_W-1:0]   TAIL_INIT  = PHYS_W'(NUM_PHYS - NUM_ARCH);
    localparam logic [NUM_PHYS-1:0] MASK_INIT  = {NUM_PHYS{1'b1}} << NUM_ARCH;

    logic [PHYS_W-1:0]   mem [NUM_PHYS];
    logic [PHYS_W-1:0]   head;
    logic [PHYS_W-1:0]   tail;
    logic [PHYS_W:0]     count;
    logic [NUM_PHYS-1:0] in_list;
    logic                err_dup_q;
    logic                err_overflow_q;

    logic ret_nz;
    logic ret_dup;
    logic ret_full;
    logic pop;
    logic push;

    assign fl.alloc_valid  = (count != '0);
    assign fl.alloc_phys   = mem[head];
    assign fl.free_count   = count;
    assign fl.err_dup      = err_dup_q;
    assign fl.err_overflow = err_overflow_q;

    // Membership is judged on the pre-edge bitmap, so returning the tag that is being
    // popped in the same cycle still counts as a duplicate.
    assign ret_nz   = fl.free_en && (fl.free_phys != '0);
    assign ret_dup  = ret_nz && in_list[fl.free_phys];
    assign ret_full = ret_nz && (count == COUNT_FULL);
    assign pop      = fl.alloc_req && fl.alloc_valid;
    assign push     = ret_nz && !in_list[fl.free_phys] && (count < COUNT_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Entries past the initial tail are don't-care; the same formula fills them.
            for (int i = 0; i < NUM_PHYS; i++) begin
                mem[i] <= PHYS_W'(NUM_ARCH + i);
            end
            head           <= '0;
            tail           <= TAIL_INIT;
            count          <= COUNT_INIT;
            in_list        <= MASK_INIT;
            err_dup_q      <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                head                <= head + 1'b1;
                in_list[mem[head]]  <= 1'b0;
            end
            if (push) begin
                mem[tail]             <= fl.free_phys;
                tail                  <= tail + 1'b1;
                in_list[fl.free_phys] <= 1'b1;
            end
            count <= count + (PHYS_W+1)'(push) - (PHYS_W+1)'(pop);
            if (ret_dup) begin
                err_dup_q <= 1'b1;
            end
            if (ret_full) begin
                err_overflow_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_phys_free_list.sv
// tb/tb_phys_free_list.sv - randomized and directed self-checking bench for phys_free_list
module tb_phys_free_list;
    localparam int NP = 64;
    localparam int NA = 32;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phys_free_list_if #(.PHYS_W(PW)) tif ();

    phys_free_list #(.NUM_PHYS(NP), .NUM_ARCH(NA), .PHYS_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (tif.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the free list as an ordered queue plus a membership set.
    int q[$];
    bit in_l[NP];
    bit m_dup;
    bit m_ovf;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            for (int i = 0; i < NP; i++) in_l[i] = (i >= NA);
            for (int i = NA; i < NP; i++) q.push_back(i);
            m_dup = 1'b0;
            m_ovf = 1'b0;
        end else begin
            bit do_pop;
            bit do_push;
            int fp;
            fp      = int'(tif.free_phys);
            do_pop  = tif.alloc_req && (q.size() != 0);
            do_push = tif.free_en && fp != 0 && !in_l[fp] && q.size() < NP - 1;
            if (tif.free_en && fp != 0 && in_l[fp]) m_dup = 1'b1;
            if (tif.free_en && fp != 0 && q.size() == NP - 1) m_ovf = 1'b1;
            if (do_pop) begin
                in_l[q[0]] = 1'b0;
                void'(q.pop_front());
            end
            if (do_push) begin
                q.push_back(fp);
                in_l[fp] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", int'(tif.alloc_valid), int'(q.size() != 0));
            chk("m_count", int'(tif.free_count), q.size());
            chk("m_dup", int'(tif.err_dup), int'(m_dup));
            chk("m_ovf", int'(tif.err_overflow), int'(m_ovf));
            if (q.size() != 0) chk("m_phys", int'(tif.alloc_phys), q[0]);
        end
    end

    task automatic step(input bit req, input bit fen, input int fp);
        tif.alloc_req = req;
        tif.free_en   = fen;
        tif.free_phys = PW'(fp);
        @(posedge clk);
        #1;
        tif.alloc_req = 1'b0;
        tif.free_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 9);
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, int'(tif.alloc_valid), 1);
        chk({tag, "_phys"}, int'(tif.alloc_phys), 32);
        chk({tag, "_count"}, int'(tif.free_count), 32);
        chk({tag, "_dup"}, int'(tif.err_dup), 0);
        chk({tag, "_ovf"}, int'(tif.err_overflow), 0);
    endtask

    initial begin
        rst = 1'b1;
        tif.alloc_req = 1'b0;
        tif.free_en   = 1'b0;
        tif.free_phys = '0;
        do_reset();
        chk_en = 1'b1;

        // T1
        check_reset_state("t1");

        // T2: drain 32..63, then one request on empty
        for (int i = 0; i < 32; i++) begin
            chk("t2_phys", int'(tif.alloc_phys), 32 + i);
            step(1'b1, 1'b0, 0);
        end
        chk("t2_valid", int'(tif.alloc_valid), 0);
        chk("t2_count", int'(tif.free_count), 0);
        step(1'b1, 1'b0, 0);
        chk("t2_valid33", int'(tif.alloc_valid), 0);
        chk("t2_count33", int'(tif.free_count), 0);
        chk("t2_dup33", int'(tif.err_dup), 0);

        // T3: push while empty with concurrent request
        step(1'b1, 1'b1, 5);
        chk("t3_valid", int'(tif.alloc_valid), 1);
        chk("t3_phys", int'(tif.alloc_phys), 5);
        chk("t3_count", int'(tif.free_count), 1);

        // T4: simultaneous pop and push, then wrap to the returned tag
        do_reset();
        step(1'b1, 1'b1, 7);
        chk("t4_count", int'(tif.free_count), 32);
        chk("t4_phys", int'(tif.alloc_phys), 33);
        for (int i = 0; i < 31; i++) step(1'b1, 1'b0, 0);
        chk("t4_wrap", int'(tif.alloc_phys), 7);
        chk("t4_count2", int'(tif.free_count), 1);

        // T5: duplicate and zero returns
        do_reset();
        step(1'b0, 1'b1, 0);
        chk("t5_zero_dup", int'(tif.err_dup), 0);
        chk("t5_zero_count", int'(tif.free_count), 32);
        step(1'b0, 1'b1, 40);
        chk("t5_dup", int'(tif.err_dup), 1);
        chk("t5_count", int'(tif.free_count), 32);
        step(1'b0, 1'b1, 0);
        chk("t5_dup_sticky", int'(tif.err_dup), 1);

        // Overflow: return 1..31 to fill, then one more
        do_reset();
        for (int t = 1; t < 32; t++) step(1'b0, 1'b1, t);
        chk("ovf_count", int'(tif.free_count), 63);
        step(1'b0, 1'b1, 5);
        chk("ovf_flag", int'(tif.err_overflow), 1);
        chk("ovf_count2", int'(tif.free_count), 63);

        // T6: reset mid-sequence
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0);
        for (int t = 32; t < 35; t++) step(1'b0, 1'b1, t);
        step(1'b0, 1'b1, 50);
        chk("t6_pre_dup", int'(tif.err_dup), 1);
        chk("t6_pre_count", int'(tif.free_count), 25);
        do_reset();
        check_reset_state("t6");

        // Random traffic checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            bit req;
            bit fen;
            int fp;
            req = ($urandom_range(0, 99) < 55);
            fen = ($urandom_range(0, 99) < 50);
            fp  = $urandom_range(0, NP - 1);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(req, fen, fp);
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
